// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 8-bit CPU core: fetches over a shared
// memory port with a req/ready handshake and drives per-opcode datapath strobes.
module cpu_control_fsm #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] opcode,
  input  logic [2:0] iaddr,
  input  logic [2:0] oaddr,
  input  logic [3:0] alu_mode_in,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] mem_addr_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       pc_src,
  output logic       sp_inc,
  output logic       sp_dec,
  output logic       reg_we,
  output logic [2:0] reg_waddr,
  output logic [2:0] reg_raddr,
  output logic [1:0] reg_wsrc,
  output logic [3:0] alu_mode,
  output logic       flag_we,
  output logic       halted,
  output logic       illegal,
  output logic       bus_error
);

  // Encodings shared with the instruction decoder (symbols.vh).
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_MOV  = 8'h01;
  localparam logic [7:0] OP_ALU  = 8'h02;
  localparam logic [7:0] OP_CMP  = 8'h03;
  localparam logic [7:0] OP_LDI  = 8'h04;
  localparam logic [7:0] OP_LDX  = 8'h05;
  localparam logic [7:0] OP_STX  = 8'h06;
  localparam logic [7:0] OP_PUSH = 8'h07;
  localparam logic [7:0] OP_POP  = 8'h08;
  localparam logic [7:0] OP_JMP  = 8'h09;
  localparam logic [7:0] OP_CALL = 8'h0A;
  localparam logic [7:0] OP_RET  = 8'h0B;
  localparam logic [7:0] OP_HLT  = 8'h0C;
  localparam logic [2:0] REG_A   = 3'd0;
  localparam logic [2:0] REG_H   = 3'd6;
  localparam logic [3:0] ALU_SUB = 4'd1;

  localparam logic [1:0] SEL_PC = 2'd0;
  localparam logic [1:0] SEL_XY = 2'd1;
  localparam logic [1:0] SEL_SP = 2'd2;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT, S_ERROR
  } state_t;

  state_t     state, state_next;
  logic [1:0] step, step_next;
  logic [7:0] wait_cnt, wait_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      step     <= 2'd0;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      step     <= step_next;
      wait_cnt <= wait_next;
    end
  end

  // Outputs are gated by reset so an in-flight request drops immediately.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = SEL_PC;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    pc_src       = 1'b0;
    sp_inc       = 1'b0;
    sp_dec       = 1'b0;
    reg_we       = 1'b0;
    reg_waddr    = 3'd0;
    reg_raddr    = 3'd0;
    reg_wsrc     = 2'd0;
    alu_mode     = 4'd0;
    flag_we      = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;
    bus_error    = 1'b0;
    state_next   = state;
    step_next    = step;
    wait_next    = wait_cnt;

    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load    = 1'b1;
            pc_inc     = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          step_next = 2'd0;
          case (opcode)
            OP_NOP:                  state_next = S_FETCH;
            OP_HLT:                  state_next = S_HALT;
            OP_MOV, OP_ALU, OP_CMP:  state_next = S_EXEC;
            OP_LDI, OP_LDX, OP_STX, OP_PUSH, OP_POP,
            OP_JMP, OP_CALL, OP_RET: state_next = S_MEM;
            default: begin
              illegal    = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          state_next = S_FETCH;
          case (opcode)
            OP_MOV: begin
              reg_we    = 1'b1;
              reg_waddr = iaddr;
              reg_raddr = oaddr;
            end
            OP_ALU: begin
              alu_mode  = alu_mode_in;
              reg_we    = 1'b1;
              reg_waddr = REG_A;
              reg_wsrc  = 2'd1;
              flag_we   = 1'b1;
            end
            OP_CMP: begin
              alu_mode = ALU_SUB;
              flag_we  = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          case (opcode)
            OP_LDI: begin
              mem_req = 1'b1;
              if (mem_ready) begin
                pc_inc     = 1'b1;
                reg_we     = 1'b1;
                reg_waddr  = iaddr;
                reg_wsrc   = SRC_MEM;
                state_next = S_FETCH;
              end
            end
            OP_LDX: begin
              mem_req      = 1'b1;
              mem_addr_sel = SEL_XY;
              if (mem_ready) begin
                reg_we     = 1'b1;
                reg_waddr  = iaddr;
                reg_wsrc   = SRC_MEM;
                state_next = S_FETCH;
              end
            end
            OP_STX: begin
              mem_req      = 1'b1;
              mem_we       = 1'b1;
              mem_addr_sel = SEL_XY;
              reg_raddr    = oaddr;
              if (mem_ready) state_next = S_FETCH;
            end
            OP_PUSH: begin
              if (step == 2'd0) begin
                sp_dec    = 1'b1;
                step_next = 2'd1;
              end else begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = SEL_SP;
                reg_raddr    = oaddr;
                if (mem_ready) state_next = S_FETCH;
              end
            end
            OP_POP: begin
              mem_req      = 1'b1;
              mem_addr_sel = SEL_SP;
              if (mem_ready) begin
                reg_we     = 1'b1;
                reg_waddr  = iaddr;
                reg_wsrc   = SRC_MEM;
                sp_inc     = 1'b1;
                state_next = S_FETCH;
              end
            end
            OP_JMP: begin
              mem_req = 1'b1;
              if (mem_ready) begin
                pc_load    = 1'b1;
                state_next = S_FETCH;
              end
            end
            OP_RET: begin
              mem_req      = 1'b1;
              mem_addr_sel = SEL_SP;
              if (mem_ready) begin
                pc_load    = 1'b1;
                sp_inc     = 1'b1;
                state_next = S_FETCH;
              end
            end
            // Target lands in H, return PC is pushed, then PC jumps via H.
            OP_CALL: begin
              case (step)
                2'd0: begin
                  mem_req = 1'b1;
                  if (mem_ready) begin
                    reg_we    = 1'b1;
                    reg_waddr = REG_H;
                    reg_wsrc  = SRC_MEM;
                    pc_inc    = 1'b1;
                    step_next = 2'd1;
                  end
                end
                2'd1: begin
                  sp_dec    = 1'b1;
                  step_next = 2'd2;
                end
                2'd2: begin
                  mem_req      = 1'b1;
                  mem_we       = 1'b1;
                  mem_addr_sel = SEL_SP;
                  if (mem_ready) step_next = 2'd3;
                end
                default: begin
                  pc_load    = 1'b1;
                  pc_src     = 1'b1;
                  step_next  = 2'd0;
                  state_next = S_FETCH;
                end
              endcase
            end
            default: state_next = S_FETCH;
          endcase
        end
        S_HALT:  halted = 1'b1;
        S_ERROR: bus_error = 1'b1;
        default: state_next = S_FETCH;
      endcase

      if (mem_req) begin
        if (mem_ready) begin
          wait_next = 8'd0;
        end else if (wait_cnt >= WAIT_LIMIT) begin
          wait_next  = 8'd0;
          state_next = S_ERROR;
        end else begin
          wait_next = wait_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: a per-instruction phase model expands
// each opcode into expected cycles (with random wait states) and compares every cycle.
module tb_cpu_control_fsm;

  localparam int TIMEOUT = 15;
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_MOV  = 8'h01;
  localparam logic [7:0] OP_ALU  = 8'h02;
  localparam logic [7:0] OP_CMP  = 8'h03;
  localparam logic [7:0] OP_LDI  = 8'h04;
  localparam logic [7:0] OP_LDX  = 8'h05;
  localparam logic [7:0] OP_STX  = 8'h06;
  localparam logic [7:0] OP_PUSH = 8'h07;
  localparam logic [7:0] OP_POP  = 8'h08;
  localparam logic [7:0] OP_JMP  = 8'h09;
  localparam logic [7:0] OP_CALL = 8'h0A;
  localparam logic [7:0] OP_RET  = 8'h0B;
  localparam logic [7:0] OP_HLT  = 8'h0C;
  localparam logic [2:0] REG_A   = 3'd0;
  localparam logic [2:0] REG_H   = 3'd6;
  localparam logic [3:0] ALU_SUB = 4'd1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] opcode = 8'h00;
  logic [2:0] iaddr = 3'd0, oaddr = 3'd0;
  logic [3:0] alu_mode_in = 4'd0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, ir_load, pc_inc, pc_load, pc_src, sp_inc, sp_dec;
  logic       reg_we, flag_we, halted, illegal, bus_error;
  logic [1:0] mem_addr_sel, reg_wsrc;
  logic [2:0] reg_waddr, reg_raddr;
  logic [3:0] alu_mode;

  cpu_control_fsm #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .iaddr(iaddr), .oaddr(oaddr),
    .alu_mode_in(alu_mode_in), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_src(pc_src), .sp_inc(sp_inc),
    .sp_dec(sp_dec), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_raddr(reg_raddr), .reg_wsrc(reg_wsrc), .alu_mode(alu_mode),
    .flag_we(flag_we), .halted(halted), .illegal(illegal), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we;
    logic [1:0] sel;
    logic       ir_load, pc_inc, pc_load, pc_src, sp_inc, sp_dec, reg_we;
    logic [2:0] waddr, raddr;
    logic [1:0] wsrc;
    logic [3:0] alu;
    logic       flag_we, halted, illegal, bus_error;
  } cyc_t;

  typedef struct {
    cyc_t       exp;
    bit         care;
    logic       rdy;
    logic [7:0] op;
    logic [2:0] ia, oa;
    logic [3:0] am;
  } ent_t;

  cyc_t       dut_obs;
  ent_t       expq[$];
  logic [7:0] cur_op;
  logic [2:0] cur_ia, cur_oa;
  logic [3:0] cur_am;
  int         n_checks = 0;
  int         n_pass = 0;

  assign dut_obs = {mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load, pc_src,
                    sp_inc, sp_dec, reg_we, reg_waddr, reg_raddr, reg_wsrc, alu_mode,
                    flag_we, halted, illegal, bus_error};

  // Address/data fields only matter while the strobe that qualifies them is high.
  function automatic cyc_t canon(input cyc_t c, input bit care);
    cyc_t r = c;
    if (!r.mem_req) begin r.mem_we = 1'b0; r.sel = 2'd0; end
    if (!r.pc_load) r.pc_src = 1'b0;
    if (!r.reg_we) begin r.waddr = 3'd0; r.wsrc = 2'd0; end
    if (!r.flag_we) r.alu = 4'd0;
    if (!care) r.raddr = 3'd0;
    return r;
  endfunction

  function automatic bit known(input logic [7:0] op);
    return op inside {OP_NOP, OP_MOV, OP_ALU, OP_CMP, OP_LDI, OP_LDX, OP_STX,
                      OP_PUSH, OP_POP, OP_JMP, OP_CALL, OP_RET, OP_HLT};
  endfunction

  task automatic push_cyc(input cyc_t s, input bit care, input logic rdy);
    ent_t e;
    e.exp = s; e.care = care; e.rdy = rdy;
    e.op = cur_op; e.ia = cur_ia; e.oa = cur_oa; e.am = cur_am;
    expq.push_back(e);
  endtask

  // A transfer: 'waits' idle request cycles (random 0..3 if negative), then the transfer.
  task automatic push_mem(input cyc_t s, input bit care, input int waits);
    cyc_t w;
    int   n;
    n = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
    w = '0;
    w.mem_req = s.mem_req; w.mem_we = s.mem_we; w.sel = s.sel; w.raddr = s.raddr;
    repeat (n) push_cyc(w, care, 1'b0);
    push_cyc(s, care, 1'b1);
  endtask

  task automatic push_int(input cyc_t s, input bit care);
    push_cyc(s, care, 1'($urandom_range(0, 1)));
  endtask

  task automatic model_instr(input logic [7:0] op, input logic [2:0] ia, input logic [2:0] oa,
                             input logic [3:0] am, input int fw, input int dw);
    cyc_t c;
    cur_op = op; cur_ia = ia; cur_oa = oa; cur_am = am;
    c = '0; c.mem_req = 1; c.ir_load = 1; c.pc_inc = 1;
    push_mem(c, 0, fw);
    c = '0; c.illegal = !known(op);
    push_int(c, 0);
    c = '0;
    case (op)
      OP_MOV: begin c.reg_we = 1; c.waddr = ia; c.raddr = oa; c.wsrc = 0; push_int(c, 1); end
      OP_ALU: begin c.alu = am; c.reg_we = 1; c.waddr = REG_A; c.wsrc = 1; c.flag_we = 1; push_int(c, 0); end
      OP_CMP: begin c.alu = ALU_SUB; c.flag_we = 1; push_int(c, 0); end
      OP_LDI: begin c.mem_req = 1; c.sel = 0; c.pc_inc = 1; c.reg_we = 1; c.waddr = ia; c.wsrc = 2; push_mem(c, 0, dw); end
      OP_LDX: begin c.mem_req = 1; c.sel = 1; c.reg_we = 1; c.waddr = ia; c.wsrc = 2; push_mem(c, 0, dw); end
      OP_STX: begin c.mem_req = 1; c.mem_we = 1; c.sel = 1; c.raddr = oa; push_mem(c, 1, dw); end
      OP_PUSH: begin
        c.sp_dec = 1; push_int(c, 0);
        c = '0; c.mem_req = 1; c.mem_we = 1; c.sel = 2; c.raddr = oa; push_mem(c, 1, dw);
      end
      OP_POP: begin c.mem_req = 1; c.sel = 2; c.reg_we = 1; c.waddr = ia; c.wsrc = 2; c.sp_inc = 1; push_mem(c, 0, dw); end
      OP_JMP: begin c.mem_req = 1; c.sel = 0; c.pc_load = 1; c.pc_src = 0; push_mem(c, 0, dw); end
      OP_RET: begin c.mem_req = 1; c.sel = 2; c.pc_load = 1; c.pc_src = 0; c.sp_inc = 1; push_mem(c, 0, dw); end
      OP_CALL: begin
        c.mem_req = 1; c.sel = 0; c.reg_we = 1; c.waddr = REG_H; c.wsrc = 2; c.pc_inc = 1; push_mem(c, 0, dw);
        c = '0; c.sp_dec = 1; push_int(c, 0);
        c = '0; c.mem_req = 1; c.mem_we = 1; c.sel = 2; push_mem(c, 0, dw);
        c = '0; c.pc_load = 1; c.pc_src = 1; push_int(c, 0);
      end
      OP_HLT: begin c.halted = 1; repeat (20) push_int(c, 0); end
      default: ;
    endcase
  endtask

  task automatic step_cycle(input ent_t e, output cyc_t obs);
    @(negedge clk);
    opcode = e.op; iaddr = e.ia; oaddr = e.oa; alu_mode_in = e.am; mem_ready = e.rdy;
    #1 obs = dut_obs;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    ent_t e;
    cyc_t obs;
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    #1 n_checks++;
    if (dut_obs !== cyc_t'('0)) $display("[TB] FAIL reset_outputs got %h want 0", dut_obs);
    else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    e.exp = '0; e.exp.mem_req = 1; e.care = 0; e.rdy = 0;
    e.op = OP_NOP; e.ia = 0; e.oa = 0; e.am = 0;
    for (int i = 0; i < 3; i++) begin
      step_cycle(e, obs);
      n_checks++;
      if (canon(obs, 0) !== canon(e.exp, 0)) $display("[TB] FAIL fetch_wait%0d got %h want %h", i, obs, e.exp);
      else n_pass++;
    end
    @(negedge clk);
    #1 reset = 1'b1;
    #1 n_checks++;
    if (mem_req !== 1'b0) $display("[TB] FAIL reset_midfetch mem_req got %b want 0", mem_req);
    else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 14) begin
        e.rdy = 1; e.exp.ir_load = 1; e.exp.pc_inc = 1;
      end
      step_cycle(e, obs);
      n_checks++;
      if (canon(obs, 0) !== canon(e.exp, 0)) $display("[TB] FAIL post_reset_fetch%0d got %h want %h", i, obs, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_nop_alu_hlt();
    ent_t e;
    cyc_t obs;
    int   k = 0;
    do_reset();
    model_instr(OP_NOP, 3'd1, 3'd2, 4'd0, 0, 0);
    model_instr(OP_ALU, 3'd3, 3'd4, 4'd2, 0, 0);
    model_instr(OP_HLT, 3'd0, 3'd0, 4'd0, 0, 0);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      step_cycle(e, obs);
      n_checks++;
      if (canon(obs, e.care) !== canon(e.exp, e.care))
        $display("[TB] FAIL nop_alu_hlt cyc%0d got %h want %h", k, canon(obs, e.care), canon(e.exp, e.care));
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_ldi_wait();
    ent_t e;
    cyc_t obs;
    int   k = 0, reqs = 0;
    do_reset();
    model_instr(OP_LDI, 3'd5, 3'd1, 4'd0, 0, 4);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      step_cycle(e, obs);
      reqs += int'(obs.mem_req);
      n_checks++;
      if (canon(obs, e.care) !== canon(e.exp, e.care))
        $display("[TB] FAIL ldi_wait cyc%0d got %h want %h", k, canon(obs, e.care), canon(e.exp, e.care));
      else n_pass++;
      k++;
    end
    n_checks++;
    if (reqs !== 6) $display("[TB] FAIL ldi_req_cycles got %0d want 6", reqs);
    else n_pass++;
  endtask

  task automatic test_call_ret();
    ent_t e;
    cyc_t obs;
    int   k = 0;
    do_reset();
    model_instr(OP_CALL, 3'd2, 3'd3, 4'd0, 0, 0);
    model_instr(OP_RET, 3'd4, 3'd5, 4'd0, 0, 0);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      step_cycle(e, obs);
      n_checks++;
      if (canon(obs, e.care) !== canon(e.exp, e.care))
        $display("[TB] FAIL call_ret cyc%0d got %h want %h", k, canon(obs, e.care), canon(e.exp, e.care));
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_illegal();
    ent_t e;
    cyc_t obs;
    int   k = 0, pulses = 0;
    do_reset();
    model_instr(8'hFF, 3'd7, 3'd7, 4'd0, 0, 0);
    model_instr(OP_NOP, 3'd0, 3'd0, 4'd0, 0, 0);
    model_instr(OP_LDX, 3'd3, 3'd0, 4'd0, 0, 1);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      step_cycle(e, obs);
      pulses += int'(obs.illegal);
      n_checks++;
      if (canon(obs, e.care) !== canon(e.exp, e.care))
        $display("[TB] FAIL illegal cyc%0d got %h want %h", k, canon(obs, e.care), canon(e.exp, e.care));
      else n_pass++;
      k++;
    end
    n_checks++;
    if (pulses !== 1) $display("[TB] FAIL illegal_pulses got %0d want 1", pulses);
    else n_pass++;
  endtask

  task automatic test_random();
    ent_t       e;
    cyc_t       obs;
    int         k = 0;
    logic [7:0] op;
    logic [7:0] ops [12] = '{OP_NOP, OP_MOV, OP_ALU, OP_CMP, OP_LDI, OP_LDX,
                             OP_STX, OP_PUSH, OP_POP, OP_JMP, OP_CALL, OP_RET};
    do_reset();
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) op = 8'hF0 | 8'($urandom_range(0, 15));
      model_instr(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)), -1, -1);
    end
    while (expq.size() > 0) begin
      e = expq.pop_front();
      step_cycle(e, obs);
      n_checks++;
      if (canon(obs, e.care) !== canon(e.exp, e.care))
        $display("[TB] FAIL random cyc%0d op %h got %h want %h", k, e.op, canon(obs, e.care), canon(e.exp, e.care));
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_timeout();
    ent_t e;
    cyc_t obs;
    do_reset();
    e.care = 0; e.op = OP_NOP; e.ia = 0; e.oa = 0; e.am = 0;
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      e.exp = '0;
      if (i < TIMEOUT) begin
        e.exp.mem_req = 1; e.rdy = 0;
      end else begin
        e.exp.bus_error = 1; e.rdy = 1'($urandom_range(0, 1));
      end
      step_cycle(e, obs);
      n_checks++;
      if (canon(obs, 0) !== canon(e.exp, 0)) $display("[TB] FAIL timeout cyc%0d got %h want %h", i, obs, e.exp);
      else n_pass++;
    end
    do_reset();
    @(negedge clk);
    #1 n_checks++;
    if (bus_error !== 1'b0 || mem_req !== 1'b1)
      $display("[TB] FAIL timeout_clear bus_error=%b mem_req=%b want 0/1", bus_error, mem_req);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nop_alu_hlt();
    test_ldi_wait();
    test_call_ret();
    test_illegal();
    test_random();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
